ddr_wcamerafifo: RTL and testbench

//  Upstream write-side stage of the camera->DDR->VGA path. Drains a show-ahead camera line FIFO
//  (read side in ddr_clk domain) into DDR as 256-word bursts to bank {write_channal, 21-bit offset}.

---
 rtl/ddr_wcamerafifo_if.sv | 30 +++
 rtl/ddr_wcamerafifo.sv | 144 ++++++++++++++
 tb/tb_ddr_wcamerafifo.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_wcamerafifo_if.sv
// rtl/ddr_wcamerafifo_if.sv - DDR write-burst request/data handshake bundle
interface ddr_wcamerafifo_if;
    logic        mem_wen;
    logic        mem_wen_valid;
    logic [22:0] wr_addr;
    logic [9:0]  wr_len;
    logic        wr_burst_data_req;
    logic [31:0] wr_burst_data;
    logic        wr_burst_finish;

    modport master (
        output mem_wen,
        output wr_addr,
        output wr_len,
        output wr_burst_data,
        input  mem_wen_valid,
        input  wr_burst_data_req,
        input  wr_burst_finish
    );

    modport slave (
        input  mem_wen,
        input  wr_addr,
        input  wr_len,
        input  wr_burst_data,
        output mem_wen_valid,
        output wr_burst_data_req,
        output wr_burst_finish
    );
endinterface

// File: rtl/ddr_wcamerafifo.sv
// rtl/ddr_wcamerafifo.sv - camera line FIFO to DDR burst writer with frame tracking
module ddr_wcamerafifo #(
    parameter logic [24:0] MAXADDR   = 25'd245_760,
    parameter logic [9:0]  BURST_LEN = 10'd256
) (
    input  logic                ddr_clk,
    input  logic                ddr_rst,
    input  logic                camera_vsync,
    input  logic [1:0]          write_channal,
    input  logic [9:0]          fifo_rd_len,
    input  logic [31:0]         fifo_rd_data,
    output logic                fifo_rd_en,
    output logic                fifo_clear,
    input  logic                ddr_ready,
    ddr_wcamerafifo_if.master   wr_bus,
    output logic                frame_wr_done,
    output logic [7:0]          frame_drop_cnt
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_REQ   = 3'd3;
    localparam logic [2:0] S_BURST = 3'd4;

    logic [2:0]  r_state;
    logic        r_vs_d0;
    logic        r_vs_d1;
    logic        r_vs_d2;
    logic [20:0] r_offset;
    logic [9:0]  r_beat;
    logic        r_pending;
    logic        r_mem_wen;
    logic [22:0] r_wr_addr;
    logic [7:0]  r_drop_cnt;

    logic        w_vs_pos;
    logic        w_in_burst;
    logic [20:0] w_next_offset;
    logic        w_last;
    logic        w_abort;
    logic [7:0]  w_drop_inc;

    // Frame-start edge detect, burst completion arithmetic and drop saturation
    always_comb begin
        w_vs_pos      = r_vs_d1 & ~r_vs_d2;
        w_in_burst    = (r_state == S_BURST);
        w_next_offset = r_offset + {11'd0, BURST_LEN};
        w_last        = ({4'd0, w_next_offset} == MAXADDR);
        w_abort       = r_pending | w_vs_pos;
        w_drop_inc    = (r_drop_cnt == 8'hFF) ? r_drop_cnt : r_drop_cnt + 8'd1;
    end

    // Pops follow the controller's word requests, capped at one burst length
    always_comb begin
        fifo_rd_en    = w_in_burst & wr_bus.wr_burst_data_req & (r_beat < BURST_LEN);
        fifo_clear    = (r_state == S_START);
        frame_wr_done = w_in_burst & wr_bus.wr_burst_finish & w_last & ~r_pending;
    end

    assign wr_bus.mem_wen       = r_mem_wen;
    assign wr_bus.wr_addr       = r_wr_addr;
    assign wr_bus.wr_len        = BURST_LEN;
    assign wr_bus.wr_burst_data = fifo_rd_data;
    assign frame_drop_cnt       = r_drop_cnt;

    // Vsync synchroniser and the frame/burst sequencing state machine
    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            r_state    <= S_IDLE;
            r_vs_d0    <= 1'b0;
            r_vs_d1    <= 1'b0;
            r_vs_d2    <= 1'b0;
            r_offset   <= 21'd0;
            r_beat     <= 10'd0;
            r_pending  <= 1'b0;
            r_mem_wen  <= 1'b0;
            r_wr_addr  <= 23'd0;
            r_drop_cnt <= 8'd0;
        end else begin
            r_vs_d0 <= camera_vsync;
            r_vs_d1 <= r_vs_d0;
            r_vs_d2 <= r_vs_d1;
            case (r_state)
                S_IDLE: begin
                    if (ddr_ready && w_vs_pos) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_wr_addr <= {write_channal, 21'd0};
                    r_offset  <= 21'd0;
                    r_pending <= 1'b0;
                    r_beat    <= 10'd0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    r_beat <= 10'd0;
                    if (w_vs_pos) begin
                        // A new frame before any burst landed is not a loss
                        if (r_offset != 21'd0) begin
                            r_drop_cnt <= w_drop_inc;
                        end
                        r_state <= S_START;
                    end else if (fifo_rd_len >= BURST_LEN) begin
                        r_mem_wen <= 1'b1;
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_vs_pos) begin
                        r_pending <= 1'b1;
                    end
                    if (wr_bus.mem_wen_valid) begin
                        r_mem_wen <= 1'b0;
                        r_state   <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (fifo_rd_en) begin
                        r_beat <= r_beat + 10'd1;
                    end
                    if (wr_bus.wr_burst_finish) begin
                        r_offset  <= w_next_offset;
                        r_wr_addr <= {r_wr_addr[22:21], w_next_offset};
                        if (w_last && !r_pending) begin
                            // Completed frame; a coincident vsync starts the next one at once
                            r_state <= w_vs_pos ? S_START : S_IDLE;
                        end else if (w_abort) begin
                            r_drop_cnt <= w_drop_inc;
                            r_state    <= S_START;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end else if (w_vs_pos) begin
                        r_pending <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_wcamerafifo.sv
// tb/tb_ddr_wcamerafifo.sv - randomized self-checking bench for ddr_wcamerafifo
module tb_ddr_wcamerafifo;
    logic        clk = 1'b0;
    logic        rst;
    logic        vsync;
    logic [1:0]  wch;
    logic [9:0]  flen;
    logic [31:0] fdata;
    logic        rd_en;
    logic        clr;
    logic        ready;
    logic        done;
    logic [7:0]  drop;

    ddr_wcamerafifo_if bus ();

    ddr_wcamerafifo dut (
        .ddr_clk           (clk),
        .ddr_rst           (rst),
        .camera_vsync      (vsync),
        .write_channal     (wch),
        .fifo_rd_len       (flen),
        .fifo_rd_data      (fdata),
        .fifo_rd_en        (rd_en),
        .fifo_clear        (clr),
        .ddr_ready         (ready),
        .wr_bus            (bus),
        .frame_wr_done     (done),
        .frame_drop_cnt    (drop)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Behavioural model: frame position counted in whole bursts
    bit         m_active  = 0;
    bit         m_pending = 0;
    bit         m_restart = 0;
    int         m_bursts  = 0;
    logic [1:0] m_bank    = 2'd0;
    int         m_drop    = 0;
    bit         in_burst  = 0;
    int         m_reqs    = 0;
    int         m_pops    = 0;
    int         clr_cnt   = 0;
    int         done_cnt  = 0;
    logic       exp_rd;
    logic       exp_done;
    logic [22:0] exp_addr;

    initial forever begin
        @(posedge clk);
        #1 fdata = $urandom;
    end

    // Per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (rst) begin
            in_burst = 0;
            m_reqs   = 0;
            m_pops   = 0;
        end else begin
            chk("wr_len", 32'(bus.wr_len), 32'd256);
            chk("wr_burst_data", bus.wr_burst_data, fdata);
            exp_rd = in_burst && bus.wr_burst_data_req && (m_reqs < 256);
            chk("fifo_rd_en", 32'(rd_en), 32'(exp_rd));
            if (in_burst && bus.wr_burst_data_req) m_reqs++;
            if (rd_en) m_pops++;
            if (clr) clr_cnt++;
            if (done) done_cnt++;
            if (!m_active) chk("mem_wen_idle", 32'(bus.mem_wen), 32'd0);
            exp_addr = {m_bank, 21'(m_bursts * 256)};
            if (bus.mem_wen) chk("wr_addr", 32'(bus.wr_addr), 32'(exp_addr));
            if (bus.mem_wen && bus.mem_wen_valid) begin
                chk("drop_at_req", 32'(drop), 32'(m_drop));
                in_burst = 1;
                m_reqs   = 0;
                m_pops   = 0;
            end
            exp_done = in_burst && bus.wr_burst_finish && (m_bursts + 1 == 960) && !m_pending;
            chk("frame_wr_done", 32'(done), 32'(exp_done));
            if (in_burst && bus.wr_burst_finish) begin
                chk("pops_per_burst", m_pops, (m_reqs < 256) ? m_reqs : 256);
                in_burst = 0;
                if (exp_done) begin
                    m_bursts = 0;
                    if (m_restart) begin
                        m_bank    = wch;
                        m_restart = 0;
                    end else begin
                        m_active = 0;
                    end
                end else if (m_pending) begin
                    m_drop    = (m_drop < 255) ? m_drop + 1 : 255;
                    m_bursts  = 0;
                    m_bank    = wch;
                    m_pending = 0;
                end else begin
                    m_bursts++;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_frame(input logic [1:0] b, input bit counts_drop);
        int c0;
        c0 = clr_cnt;
        wch = b;
        m_active = 1;
        m_bank = b;
        m_bursts = 0;
        if (counts_drop) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        vsync = 1;
        cyc(8);
        vsync = 0;
        chk("fifo_clear_once", clr_cnt - c0, 1);
        cyc(3);
    endtask

    // Emulates the DDR controller for one burst; lit[23] requests a literal address check
    task automatic burst(input int nreq, input bit vs_mid, input bit vs_coinc, input logic [23:0] lit);
        int t;
        t = 0;
        while (!bus.mem_wen && t < 200) begin
            cyc(1);
            t++;
        end
        if (!bus.mem_wen) begin
            chk("mem_wen_timeout", 32'(bus.mem_wen), 32'd1);
            return;
        end
        if (lit[23]) chk("wr_addr_literal", 32'(bus.wr_addr), 32'(lit[22:0]));
        cyc($urandom_range(0, 2));
        bus.mem_wen_valid = 1;
        cyc(1);
        bus.mem_wen_valid = 0;
        if (vs_mid) begin
            vsync = 1;
            m_pending = 1;
        end
        for (int i = 0; i < nreq; i++) begin
            bus.wr_burst_data_req = 1;
            cyc(1);
            bus.wr_burst_data_req = 0;
            if ($urandom_range(0, 3) == 0) cyc(1);
        end
        if (vs_mid) cyc(6);
        cyc($urandom_range(0, 2));
        if (vs_coinc) begin
            vsync = 1;
            m_restart = 1;
            cyc(2);
        end
        bus.wr_burst_finish = 1;
        cyc(1);
        bus.wr_burst_finish = 0;
        vsync = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int d0;
        int hi;
        rst = 1; vsync = 0; wch = 2'd0; flen = 10'd0; ready = 1;
        bus.mem_wen_valid = 0; bus.wr_burst_data_req = 0; bus.wr_burst_finish = 0;
        cyc(3);
        chk("rst_mem_wen", 32'(bus.mem_wen), 32'd0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_clear", 32'(clr), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        rst = 0;
        cyc(2);

        // first frame start, bank 0
        flen = 10'd256;
        start_frame(2'd0, 0);
        chk("t1_mem_wen", 32'(bus.mem_wen), 32'd1);
        chk("t1_wr_addr", 32'(bus.wr_addr), 32'h0);
        // 257 requests in a single burst
        burst(257, 0, 0, 24'h0);
        for (int i = 1; i < 16; i++) burst($urandom_range(0, 3), 0, 0, 24'h0);
        // vsync mid-burst at offset 0x1000
        burst(2, 1, 0, {1'b1, 23'h001000});
        chk("t5_drop", 32'(drop), 32'd1);
        burst(1, 0, 0, {1'b1, 23'h000000});
        // level one short of a burst holds the request off
        flen = 10'd255;
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (bus.mem_wen) hi++;
        end
        chk("t3_no_req_below_burst", hi, 0);
        flen = 10'd256;
        cyc(2);
        chk("t3_req_at_burst", 32'(bus.mem_wen), 32'd1);
        burst(3, 0, 0, {1'b1, 23'h000100});
        burst(0, 0, 0, 24'h0);
        // vsync in WAIT past offset 0, then again at offset 0
        flen = 10'd100;
        start_frame(2'd1, 1);
        start_frame(2'd3, 0);
        flen = 10'($urandom_range(256, 1023));
        burst(2, 0, 0, {1'b1, 23'h600000});
        for (int i = 0; i < 2; i++) burst($urandom_range(0, 4), 0, 0, 24'h0);
        chk("t_wait_abort_drop", 32'(drop), 32'd2);

        // reset during a burst
        while (!bus.mem_wen) cyc(1);
        bus.mem_wen_valid = 1;
        cyc(1);
        bus.mem_wen_valid = 0;
        bus.wr_burst_data_req = 1;
        cyc(2);
        rst = 1;
        m_active = 0; m_pending = 0; m_bursts = 0; m_drop = 0; m_bank = 2'd0;
        cyc(1);
        chk("t6_mem_wen", 32'(bus.mem_wen), 32'd0);
        chk("t6_rd_en", 32'(rd_en), 32'd0);
        chk("t6_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("t6_drop", 32'(drop), 32'd0);
        rst = 0;
        bus.wr_burst_data_req = 0;
        cyc(20);

        // full frame into bank 2
        flen = 10'd256;
        d0 = done_cnt;
        start_frame(2'd2, 0);
        burst($urandom_range(0, 2), 0, 0, {1'b1, 23'h400000});
        burst($urandom_range(0, 2), 0, 0, {1'b1, 23'h400100});
        for (int i = 2; i < 960; i++) burst($urandom_range(0, 2), 0, 0, 24'h0);
        chk("t2_done_once", done_cnt - d0, 1);
        cyc(20);
        chk("t2_mem_wen_after", 32'(bus.mem_wen), 32'd0);

        // ddr_ready low keeps the block in IDLE
        ready = 0;
        vsync = 1;
        cyc(8);
        vsync = 0;
        cyc(10);
        ready = 1;
        cyc(5);

        // full frame whose last finish coincides with a new vsync
        d0 = done_cnt;
        start_frame(2'd1, 0);
        for (int i = 0; i < 959; i++) burst($urandom_range(0, 2), 0, 0, 24'h0);
        burst(1, 0, 1, 24'h0);
        chk("coinc_done_once", done_cnt - d0, 1);
        burst(1, 0, 0, {1'b1, 23'h200000});
        chk("coinc_no_drop", 32'(drop), 32'd0);
        cyc(5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
